// File: rtl/hilo_unit.sv
// hilo_unit
//   Owns the architectural HI/LO register pair. Writes from the EX-stage
//   arithmetic unit (MULT/MULTU/MTHI/MTLO) travel through a MEM latch and a
//   WB latch and commit to r_hi/r_lo at the end of WB. Read values for EX are
//   returned on hi/lo.
//
//   Build option HILO_BYPASS_EN:
//     defined   : hi/lo forward the youngest in-flight write per half
//                 (MEM, then WB, then the architectural register);
//                 hazard is tied to 0.
//     undefined : hi/lo show the architectural registers only; hazard asks
//                 the pipeline controller to hold an EX reader until no
//                 write is in flight (at most 2 cycles).
//   Latch and commit behaviour is the same in both builds.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   stall    in   hold the MEM latch, bubble into WB
//   flush    in   squash the EX input and the MEM latch
//   ex_we    in   [1]=HI, [0]=LO write enables from EX
//   ex_hi    in   HI write data from EX
//   ex_lo    in   LO write data from EX
//   ex_read  in   EX instruction reads HI or LO this cycle
//   hi, lo   out  read values returned to EX
//   arch_hi  out  committed HI
//   arch_lo  out  committed LO
//   hazard   out  stall request to the pipeline controller

module hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [1:0]       ex_we,
    input  logic [WIDTH-1:0] ex_hi,
    input  logic [WIDTH-1:0] ex_lo,
    input  logic             ex_read,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] arch_hi,
    output logic [WIDTH-1:0] arch_lo,
    output logic             hazard
);

    logic [1:0]       m_we;
    logic [WIDTH-1:0] m_hi;
    logic [WIDTH-1:0] m_lo;
    logic [1:0]       w_we;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_we <= 2'b00;
            m_hi <= '0;
            m_lo <= '0;
            w_we <= 2'b00;
            w_hi <= '0;
            w_lo <= '0;
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            // Commit is unconditional: whatever reached WB retires.
            if (w_we[1]) r_hi <= w_hi;
            if (w_we[0]) r_lo <= w_lo;

            // Data follows MEM unconditionally; only the enables are bubbled.
            w_we <= (stall || flush) ? 2'b00 : m_we;
            w_hi <= m_hi;
            w_lo <= m_lo;

            // Flush wins over stall so an excepting write can never be held.
            if (flush) begin
                m_we <= 2'b00;
            end else if (!stall) begin
                m_we <= ex_we;
                m_hi <= ex_hi;
                m_lo <= ex_lo;
            end
        end
    end

    assign arch_hi = r_hi;
    assign arch_lo = r_lo;

`ifdef HILO_BYPASS_EN
    // The current EX write is deliberately not a forwarding source; that
    // would close a loop through the ALU.
    always_comb begin
        hi = r_hi;
        if (w_we[1]) hi = w_hi;
        if (m_we[1]) hi = m_hi;
        lo = r_lo;
        if (w_we[0]) lo = w_lo;
        if (m_we[0]) lo = m_lo;
    end

    logic unused_read;
    assign unused_read = ex_read;
    assign hazard      = 1'b0;
`else
    assign hi     = r_hi;
    assign lo     = r_lo;
    assign hazard = ex_read & ((m_we != 2'b00) | (w_we != 2'b00));
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit. The stimulus thread drives one cycle at a
// time, pushes the outputs the reference model predicts for that cycle, and
// then advances the model. A monitor pops and compares on every falling edge.
// Directed checks with literal values from the intended scenarios run first,
// followed by randomized traffic including stalls, flushes and resets.

module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  ex_we = 2'b00;
    logic [31:0] ex_hi = '0;
    logic [31:0] ex_lo = '0;
    logic        ex_read = 1'b0;
    logic [31:0] hi, lo, arch_hi, arch_lo;
    logic        hazard;

    hilo_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_we(ex_we), .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_read(ex_read),
        .hi(hi), .lo(lo), .arch_hi(arch_hi), .arch_lo(arch_lo),
        .hazard(hazard)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc_no = 0;

    typedef struct {
        logic [31:0] hi, lo, ahi, alo;
        logic        hz;
        int          id;
    } exp_t;
    exp_t sb[$];

    // Reference model: committed values plus the ordered list of writes still
    // travelling (index 0 = older/WB, index 1 = younger/MEM).
    logic [31:0] a_hi, a_lo;
    typedef struct { logic [1:0] we; logic [31:0] h, l; } wr_t;
    wr_t fly[2];

    function automatic wr_t nop();
        wr_t n;
        n.we = 2'b00; n.h = '0; n.l = '0;
        return n;
    endfunction

    task automatic model_reset();
        a_hi = '0; a_lo = '0;
        fly[0] = nop(); fly[1] = nop();
    endtask

    function automatic exp_t predict(input logic rd);
        exp_t e;
        logic any;
        e.ahi = a_hi; e.alo = a_lo;
        any = (fly[0].we != 2'b00) || (fly[1].we != 2'b00);
`ifdef HILO_BYPASS_EN
        // Youngest value = committed state with in-flight writes replayed in order.
        e.hi = a_hi; e.lo = a_lo;
        for (int k = 0; k < 2; k++) begin
            if (fly[k].we[1]) e.hi = fly[k].h;
            if (fly[k].we[0]) e.lo = fly[k].l;
        end
        e.hz = 1'b0;
        if (any) e.hz = 1'b0;
`else
        e.hi = a_hi; e.lo = a_lo;
        e.hz = rd && any;
`endif
        e.id = cyc_no;
        return e;
    endfunction

    task automatic model_step(input logic r, st, fl, input logic [1:0] we,
                              input logic [31:0] h, l);
        wr_t nw;
        if (r) begin
            model_reset();
        end else begin
            if (fly[0].we[1]) a_hi = fly[0].h;
            if (fly[0].we[0]) a_lo = fly[0].l;
            nw.we = we; nw.h = h; nw.l = l;
            fly[0] = (st || fl) ? nop() : fly[1];
            if (fl)       fly[1] = nop();
            else if (!st) fly[1] = nw;
        end
    endtask

    task automatic cyc(input logic r, st, fl, input logic [1:0] we,
                       input logic [31:0] h, l, input logic rd);
        @(posedge clk);
        #1;
        rst = r; stall = st; flush = fl; ex_we = we; ex_hi = h; ex_lo = l; ex_read = rd;
        cyc_no++;
        sb.push_back(predict(rd));
        model_step(r, st, fl, we, h, l);
    endtask

    task automatic idle(input logic rd);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, $urandom, $urandom, rd);
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc_no, act, exp_v);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest prediction.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                total += 5;
                if (hi !== e.hi)      begin bad++; $display("FAIL sb_hi cycle=%0d got=%h want=%h", e.id, hi, e.hi); end
                if (lo !== e.lo)      begin bad++; $display("FAIL sb_lo cycle=%0d got=%h want=%h", e.id, lo, e.lo); end
                if (arch_hi !== e.ahi) begin bad++; $display("FAIL sb_arch_hi cycle=%0d got=%h want=%h", e.id, arch_hi, e.ahi); end
                if (arch_lo !== e.alo) begin bad++; $display("FAIL sb_arch_lo cycle=%0d got=%h want=%h", e.id, arch_lo, e.alo); end
                if (hazard !== e.hz)  begin bad++; $display("FAIL sb_hazard cycle=%0d got=%b want=%b", e.id, hazard, e.hz); end
            end
        end
    end

    initial begin
        logic bypass;
`ifdef HILO_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state
        idle(1'b1);
        @(negedge clk);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_arch_hi", arch_hi, 32'h0);
        chk("rst_arch_lo", arch_lo, 32'h0);
        chk("rst_hazard", {31'b0, hazard}, 32'h0);

        // MULT then back-to-back reader
        cyc(0, 0, 0, 2'b11, 32'h0000_0001, 32'hFFFF_FFFE, 0);      // n
        idle(1'b1);                                                // n+1
        @(negedge clk);
        if (bypass) begin
            chk("mult_fwd_hi", hi, 32'h1);
            chk("mult_fwd_lo", lo, 32'hFFFF_FFFE);
        end else begin
            chk("mult_hz_n1", {31'b0, hazard}, 32'h1);
        end
        idle(1'b1);                                                // n+2
        @(negedge clk);
        chk("mult_hz_n2", {31'b0, hazard}, bypass ? 32'h0 : 32'h1);
        chk("mult_arch_early", arch_hi, 32'h0);
        idle(1'b1);                                                // n+3
        @(negedge clk);
        chk("mult_hz_n3", {31'b0, hazard}, 32'h0);
        chk("mult_arch_hi", arch_hi, 32'h1);
        chk("mult_arch_lo", arch_lo, 32'hFFFF_FFFE);

        // Partial-write priority
        cyc(0, 0, 0, 2'b10, 32'hAAAA_AAAA, 32'h0BAD_0BAD, 0);      // n  MTHI
        cyc(0, 0, 0, 2'b01, 32'h0BAD_0BAD, 32'h5555_5555, 0);      // n+1 MTLO
        idle(1'b0);                                                // n+2
        @(negedge clk);
        if (bypass) begin
            chk("part_fwd_hi", hi, 32'hAAAA_AAAA);
            chk("part_fwd_lo", lo, 32'h5555_5555);
        end
        idle(1'b0);
        idle(1'b0);                                                // n+4
        @(negedge clk);
        chk("part_arch_hi", arch_hi, 32'hAAAA_AAAA);
        chk("part_arch_lo", arch_lo, 32'h5555_5555);

        // Flush squash
        cyc(0, 0, 0, 2'b11, 32'h1234, 32'h5678, 0);                // n
        cyc(0, 0, 1, 2'b01, 32'h0, 32'h9, 0);                      // n+1
        idle(1'b0);                                                // n+2
        @(negedge clk);
        chk("flush_hi", hi, 32'hAAAA_AAAA);
        chk("flush_lo", lo, 32'h5555_5555);
        repeat (3) idle(1'b0);
        @(negedge clk);
        chk("flush_arch_hi", arch_hi, 32'hAAAA_AAAA);
        chk("flush_arch_lo", arch_lo, 32'h5555_5555);

        // Stall hold
        cyc(0, 0, 0, 2'b01, 32'h0, 32'h7, 0);                      // n
        cyc(0, 1, 0, 2'b00, 32'h0, 32'h0, 0);                      // n+1
        @(negedge clk);
        if (bypass) chk("stall_fwd_n1", lo, 32'h7);
        cyc(0, 1, 0, 2'b00, 32'h0, 32'h0, 0);                      // n+2
        @(negedge clk);
        if (bypass) chk("stall_fwd_n2", lo, 32'h7);
        idle(1'b0);                                                // n+3
        idle(1'b0);                                                // n+4
        @(negedge clk);
        chk("stall_arch_n4", arch_lo, 32'h5555_5555);
        idle(1'b0);                                                // n+5
        @(negedge clk);
        chk("stall_arch_n5", arch_lo, 32'h7);

        // Flush over stall
        cyc(0, 0, 0, 2'b10, 32'hDEAD_BEEF, 32'h0, 0);              // n
        cyc(0, 1, 1, 2'b00, 32'h0, 32'h0, 0);                      // n+1
        repeat (4) idle(1'b0);
        @(negedge clk);
        chk("fos_arch_hi", arch_hi, 32'hAAAA_AAAA);
        chk("fos_hi", hi, 32'hAAAA_AAAA);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic r, st, fl;
            r  = ($urandom_range(0, 99) < 2);
            st = ($urandom_range(0, 99) < 20);
            fl = ($urandom_range(0, 99) < 10);
            cyc(r, st, fl, 2'($urandom_range(0, 3)), $urandom, $urandom,
                1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Owns the architectural HI/LO register pair.
- Is the write end of the HI/LO interface driven by the EX-stage arithmetic unit (MULT/MULTU/MTHI/MTLO writes).
- Carries each write through MEM and WB pipeline latches and commits it at the end of WB.
- Returns forwarded HI/LO read values to EX, so a dependent MFHI/MFLO/MADD-style consumer sees the youngest in-flight value.

Parameters:
- WIDTH, 32, data width of HI and of LO.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  holds the MEM latch; WB receives a bubble.
- flush  input  1  squashes the EX input and the MEM latch (exception at MEM).
- ex_we  input  2  write enables from EX; bit1 = HI, bit0 = LO (2'b11 for MULT/MULTU, 2'b10 MTHI, 2'b01 MTLO).
- ex_hi  input  WIDTH  HI write data from EX.
- ex_lo  input  WIDTH  LO write data from EX.
- ex_read  input  1  EX instruction reads HI or LO this cycle.
- hi  output  WIDTH  forwarded HI value to EX.
- lo  output  WIDTH  forwarded LO value to EX.
- arch_hi  output  WIDTH  committed HI.
- arch_lo  output  WIDTH  committed LO.
- hazard  output  1  stall request to the pipeline controller.

Behaviour:
- State:
  - MEM latch {m_we[1:0], m_hi, m_lo}.
  - WB latch {w_we[1:0], w_hi, w_lo}.
  - Architectural registers r_hi, r_lo.
- Reset (rst=1 at edge):
  - m_we = w_we = 0; all data latches = 0; r_hi = r_lo = 0.
  - All outputs therefore read 0 and hazard = 0 the cycle after reset.
  - Reset mid-operation discards every in-flight write.
- Per rising edge, when not in reset:
  - Commit: for each bit of w_we that is set, the corresponding r_hi/r_lo takes w_hi/w_lo. Unset halves hold. Commit happens regardless of stall and flush.
  - WB latch: takes the MEM latch contents. If stall or flush is high, w_we is set to 0 (bubble) instead.
  - MEM latch:
    - flush=1 gives m_we=0 and takes priority over stall.
    - Otherwise stall=1 holds the current contents.
    - Otherwise it captures {ex_we, ex_hi, ex_lo}.
  - Data latches may capture arbitrary data when the matching enable is 0.
- Latency: an EX write at cycle n sits in MEM in n+1, WB in n+2, and is visible on arch_* from n+3.
- Forwarding (combinational), evaluated per half independently:
  - hi = m_hi if m_we[1]; else w_hi if w_we[1]; else r_hi.
  - lo follows the same rule using bit0.
  - MEM has priority over WB, which has priority over the architectural register.
  - The current EX write is never forwarded to itself (avoids a combinational loop through the ALU).
- Partial writes: an MTHI in MEM and an MTLO in WB forward independently: hi comes from MEM, lo from WB.
- Simultaneous commit and read: a WB write committing at an edge is read from r_* after the edge; no gap.
- hazard = 0 whenever bypass is compiled in.

Optional Feature:
- Macro: HILO_BYPASS_EN.
- Defined: forwarding as above; hazard tied to 0.
- Undefined:
  - hi = r_hi and lo = r_lo (no forwarding).
  - hazard = ex_read & ((m_we != 0) | (w_we != 0)).
  - The controller stalls EX until the pipeline drains. Worst case is 2 stall cycles.
  - Latch and commit behaviour is identical in both builds.

Test Plan:
- Reset check: rst=1 for 2 cycles, then release -> hi = lo = arch_hi = arch_lo = 0, hazard = 0.
- MULT result, then a back-to-back reader:
  - Stimulus: ex_we=2'b11, ex_hi=32'h0000_0001, ex_lo=32'hFFFF_FFFE at cycle n; ex_read=1 at n+1.
  - Bypass build: hi=32'h1, lo=32'hFFFF_FFFE at n+1.
  - Non-bypass build: hazard=1 at n+1 and n+2, 0 at n+3.
  - Both builds: arch_* updated from n+3.
- Partial-write priority:
  - Stimulus: MTHI 32'hAAAA_AAAA at n, then MTLO 32'h5555_5555 at n+1.
  - At n+2: hi=32'hAAAA_AAAA (from WB), lo=32'h5555_5555 (from MEM).
  - Afterwards: arch_hi=32'hAAAA_AAAA and arch_lo=32'h5555_5555; neither write clobbers the other half.
- Flush squash:
  - Stimulus: ex_we=2'b11 with data 32'h1234/32'h5678 at n; flush=1 at n+1 while ex_we=2'b01, ex_lo=32'h9.
  - Result: arch_hi and arch_lo never change; hi/lo revert to arch values at n+2.
- Stall hold:
  - Stimulus: ex_we=2'b01, ex_lo=32'h7 at n; stall=1 at n+1 and n+2; stall=0 at n+3.
  - Result: lo forwards 32'h7 throughout; arch_lo becomes 32'h7 exactly once, visible from n+5.
- Flush over stall: flush=1 and stall=1 on the same edge with a valid MEM latch -> MEM cleared (m_we=0), not held; no commit of that write ever occurs.
